// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO write-side signal bundle for fifo_wr_arbiter.
// master = arbiter side, slave = producers plus FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 8
);
  localparam int unsigned OW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] data;
  logic [N_REQ-1:0]    gnt;
  logic                fifo_wr_en;
  logic [DW-1:0]       fifo_data_in;
  logic                fifo_rd_en;
  logic                fifo_full;
  logic [3:0]          fifo_count;
  logic [OW-1:0]       owner;
  logic                busy;

  modport master (
    input  req, data, fifo_rd_en, fifo_full, fifo_count,
    output gnt, fifo_wr_en, fifo_data_in, owner, busy
  );

  modport slave (
    output req, data, fifo_rd_en, fifo_full, fifo_count,
    input  gnt, fifo_wr_en, fifo_data_in, owner, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between N_REQ producers.
// Optional macro FIFO_ARB_PRIO_EN gives producer 0 absolute priority at grant start.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DW           = 8,
  parameter int unsigned BURST_MAX    = 4,
  parameter int unsigned THROTTLE_LVL = 6
) (
  input logic               clk,
  input logic               reset,
  fifo_wr_arbiter_if.master bus
);

  localparam int unsigned OW = $clog2(N_REQ);
  localparam int unsigned CW = 3;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;
  logic [OW-1:0] pick;
  logic [OW-1:0] rr_next;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          busy_q, busy_d;
  logic          accept;

  // Circular search from rr_ptr; descending loop so the nearest requester wins.
  always_comb begin
    pick = rr_ptr_q;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[OW'(rr_ptr_q + OW'(i))]) pick = OW'(rr_ptr_q + OW'(i));
    end
`ifdef FIFO_ARB_PRIO_EN
    if (bus.req[0]) pick = '0;
`endif
  end

`ifdef FIFO_ARB_PRIO_EN
  assign rr_next = (owner_q == '0) ? rr_ptr_q : OW'(owner_q + 1'b1);
`else
  assign rr_next = OW'(owner_q + 1'b1);
`endif

  // Next-state and write strobes; writes are masked while reset is asserted.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    accept     = 1'b0;
    bus.gnt    = '0;
    case (state_q)
      S_IDLE: begin
        if (|bus.req && (bus.fifo_count < 4'(THROTTLE_LVL))) begin
          state_d    = S_GRANT;
          owner_d    = pick;
          beat_cnt_d = '0;
        end
      end
      S_GRANT: begin
        accept = bus.req[owner_q] && !bus.fifo_full && !bus.fifo_rd_en && !reset;
        if (!bus.req[owner_q]) begin
          state_d  = S_IDLE;
          rr_ptr_d = rr_next;
        end else if (accept) begin
          beat_cnt_d = CW'(beat_cnt_q + 1'b1);
          if (beat_cnt_q == CW'(BURST_MAX - 1)) begin
            state_d  = S_IDLE;
            rr_ptr_d = rr_next;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    bus.gnt[owner_q] = accept;
    bus.fifo_wr_en   = accept;
    busy_d           = (state_d == S_GRANT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.fifo_data_in = bus.data[owner_q*DW +: DW];
  assign bus.owner        = owner_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (honours FIFO_ARB_PRIO_EN when defined).
module tb_fifo_wr_arbiter;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned DW    = 8;
`ifdef FIFO_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

  fifo_wr_arbiter #(
    .N_REQ(4), .DW(8), .BURST_MAX(4), .THROTTLE_LVL(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_lane(input int i);
    return 8'(8'hA0 + 8'h11 * i);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0; bus.fifo_full = 1'b0; bus.fifo_rd_en = 1'b0; bus.fifo_count = '0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.data = 32'hD3C2B1A0;
    reset = 1'b1; bus.req = 4'b1111;
    bus.fifo_full = 1'b0; bus.fifo_rd_en = 1'b0; bus.fifo_count = '0;
    cyc(); cyc(); #1;
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", bus.fifo_wr_en); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.owner !== 2'd0) begin n_bad++; $display("FAIL reset_owner: got %0d want 0", bus.owner); end
    n_cmp++; if (bus.fifo_data_in !== 8'hA0) begin n_bad++; $display("FAIL reset_data: got %h want a0", bus.fifo_data_in); end
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] e;
    do_reset();
    bus.req = 4'b1111; #1;
    for (int b = 0; b < 5; b++) begin
      e = PRIO ? 2'd0 : 2'(b);
      n_cmp++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL rr_idle_gap burst %0d: busy %b gnt %b want 0 0000", b, bus.busy, bus.gnt); end
      for (int k = 0; k < 4; k++) begin
        cyc(); #1;
        n_cmp++; if (bus.owner !== e) begin n_bad++; $display("FAIL rr_owner burst %0d beat %0d: got %0d want %0d", b, k, bus.owner, e); end
        n_cmp++; if (bus.gnt !== 4'(1 << e) || bus.fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL rr_gnt burst %0d beat %0d: gnt %b wr %b want %b 1", b, k, bus.gnt, bus.fifo_wr_en, 4'(1 << e)); end
        n_cmp++; if (bus.fifo_data_in !== exp_lane(int'(e))) begin n_bad++; $display("FAIL rr_data burst %0d: got %h want %h", b, bus.fifo_data_in, exp_lane(int'(e))); end
      end
      cyc(); #1;
    end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rr_final_idle: busy %b want 0", bus.busy); end
    bus.req = '0;
  endtask

  task automatic test_full_stall();
    do_reset();
    bus.req = 4'b0100;
    cyc(); #1;
    n_cmp++; if (bus.owner !== 2'd2 || bus.gnt !== 4'b0100) begin n_bad++; $display("FAIL full_first_beat: owner %0d gnt %b want 2 0100", bus.owner, bus.gnt); end
    cyc();
    bus.fifo_full = 1'b1; #1;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) begin cyc(); #1; end
      n_cmp++; if (bus.gnt !== 4'b0000 || bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL full_stall cycle %0d: gnt %b wr %b want 0000 0", s, bus.gnt, bus.fifo_wr_en); end
      n_cmp++; if (bus.busy !== 1'b1 || bus.owner !== 2'd2) begin n_bad++; $display("FAIL full_hold cycle %0d: busy %b owner %0d want 1 2", s, bus.busy, bus.owner); end
    end
    cyc();
    bus.fifo_full = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin cyc(); #1; end
      n_cmp++; if (bus.gnt !== 4'b0100 || bus.fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL full_resume beat %0d: gnt %b wr %b want 0100 1", k, bus.gnt, bus.fifo_wr_en); end
    end
    cyc(); #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL full_burst_end: busy %b gnt %b want 0 0000", bus.busy, bus.gnt); end
    bus.req = '0;
  endtask

  task automatic test_rd_en();
    int beats;
    beats = 0;
    do_reset();
    bus.req = 4'b0001;
    cyc(); #1;
    if (bus.fifo_wr_en === 1'b1) beats++;
    cyc();
    bus.fifo_rd_en = 1'b1; #1;
    n_cmp++; if (bus.gnt !== 4'b0000 || bus.fifo_wr_en !== 1'b0 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL rd_en_block: gnt %b wr %b busy %b want 0000 0 1", bus.gnt, bus.fifo_wr_en, bus.busy); end
    cyc();
    bus.fifo_rd_en = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      if (bus.fifo_wr_en === 1'b1) beats++;
      cyc(); #1;
    end
    n_cmp++; if (beats !== 4) begin n_bad++; $display("FAIL rd_en_total_beats: got %0d want 4", beats); end
    bus.req = '0;
  endtask

  task automatic test_throttle();
    do_reset();
    bus.fifo_count = 4'd6; bus.req = 4'b0010; #1;
    for (int s = 0; s < 3; s++) begin
      n_cmp++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL throttle_hold cycle %0d: busy %b gnt %b want 0 0000", s, bus.busy, bus.gnt); end
      cyc(); #1;
    end
    bus.fifo_count = 4'd5; #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL throttle_latency: busy %b want 0", bus.busy); end
    cyc(); #1;
    n_cmp++; if (bus.busy !== 1'b1 || bus.owner !== 2'd1 || bus.gnt !== 4'b0010) begin n_bad++; $display("FAIL throttle_grant: busy %b owner %0d gnt %b want 1 1 0010", bus.busy, bus.owner, bus.gnt); end
    bus.fifo_count = 4'd8;
    cyc(); #1;
    n_cmp++; if (bus.gnt !== 4'b0010 || bus.fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL throttle_midburst: gnt %b wr %b want 0010 1", bus.gnt, bus.fifo_wr_en); end
    bus.req = '0; bus.fifo_count = '0;
    cyc(); cyc();
  endtask

  task automatic test_drop();
    logic [1:0] e;
    e = PRIO ? 2'd0 : 2'd2;
    do_reset();
    bus.req = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      cyc(); #1;
      n_cmp++; if (bus.owner !== 2'd1 || bus.gnt !== 4'b0010) begin n_bad++; $display("FAIL drop_beat %0d: owner %0d gnt %b want 1 0010", k, bus.owner, bus.gnt); end
    end
    cyc();
    bus.req = 4'b0000; #1;
    n_cmp++; if (bus.gnt !== 4'b0000 || bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL drop_no_accept: gnt %b wr %b want 0000 0", bus.gnt, bus.fifo_wr_en); end
    cyc(); #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL drop_to_idle: busy %b want 0", bus.busy); end
    bus.req = 4'b0101;
    cyc(); #1;
    n_cmp++; if (bus.owner !== e || bus.busy !== 1'b1) begin n_bad++; $display("FAIL drop_next_owner: owner %0d busy %b want %0d 1", bus.owner, bus.busy, e); end
    bus.req = '0;
    cyc(); cyc();
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] e;
    e = PRIO ? 2'd0 : 2'd2;
    do_reset();
    bus.req = 4'b0010;
    repeat (5) cyc();
    bus.req = 4'b1111;
    cyc(); #1;
    n_cmp++; if (bus.owner !== e || bus.busy !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_owner: owner %0d busy %b want %0d 1", bus.owner, bus.busy, e); end
    cyc();
    reset = 1'b1; #1;
    n_cmp++; if (bus.gnt !== 4'b0000 || bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL midrst_no_write: gnt %b wr %b want 0000 0", bus.gnt, bus.fifo_wr_en); end
    cyc(); #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.owner !== 2'd0) begin n_bad++; $display("FAIL midrst_state: busy %b owner %0d want 0 0", bus.busy, bus.owner); end
    reset = 1'b0;
    cyc(); #1;
    n_cmp++; if (bus.owner !== 2'd0 || bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL midrst_rr_restart: owner %0d gnt %b want 0 0001", bus.owner, bus.gnt); end
    bus.req = '0;
    cyc(); cyc();
  endtask

  task automatic test_prio_rotation();
    logic [1:0] rot [3];
    logic [1:0] e;
    rot = '{2'd0, 2'd1, 2'd3};
    do_reset();
    bus.req = 4'b1011; #1;
    for (int b = 0; b < 3; b++) begin
      e = PRIO ? 2'd0 : rot[b];
      for (int k = 0; k < 4; k++) begin
        cyc(); #1;
        n_cmp++; if (bus.owner !== e || bus.gnt !== 4'(1 << e)) begin n_bad++; $display("FAIL rot_owner burst %0d beat %0d: owner %0d gnt %b want %0d %b", b, k, bus.owner, bus.gnt, e, 4'(1 << e)); end
      end
      cyc(); #1;
    end
    bus.req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want normal finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_full_stall();
    test_rd_en();
    test_throttle();
    test_drop();
    test_reset_mid_burst();
    test_prio_rotation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
